// File: rtl/cacheline_adapter.sv
// Cacheline adapter: 256-bit arbiter line requests <-> 4-beat 64-bit memory bursts.
// Optional saturating performance counters are built when CACHELINE_ADAPTER_PERF_EN is defined.
module cacheline_adapter #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
`ifdef CACHELINE_ADAPTER_PERF_EN
   output logic [31:0]        perf_rd_cnt,
   output logic [31:0]        perf_wr_cnt,
   output logic [31:0]        perf_busy_cnt,
`endif
   input  logic               line_read,
   input  logic               line_write,
   input  logic [ADDR_W-1:0]  line_address,
   input  logic [LINE_W-1:0]  line_wdata,
   output logic [LINE_W-1:0]  line_rdata,
   output logic               line_resp,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BURST_W-1:0] mem_wdata,
   input  logic [BURST_W-1:0] mem_rdata,
   input  logic               mem_resp
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFS_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RD_BURST = 2'd1,
      S_WR_BURST = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_beat_cnt;
   logic [CNT_W-1:0]    w_next_beat;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wline;
   logic [LINE_W-1:0]   w_wline_next;
   logic [LINE_W-1:0]   r_rbuf;
   logic [LINE_W-1:0]   w_rline;
   logic [LINE_W-1:0]   r_line_rdata;
   logic                r_line_resp;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [BURST_W-1:0]  r_mem_wdata;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_aligned_addr;
   logic                w_unused_addr_bits;

   function automatic logic [BURST_W-1:0] f_beat(input logic [LINE_W-1:0] line,
                                                 input logic [CNT_W-1:0]  idx);
      return line[int'(idx)*BURST_W +: BURST_W];
   endfunction

   assign w_accept           = (r_state == S_IDLE) && (line_write || line_read);
   assign w_aligned_addr     = {line_address[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
   assign w_unused_addr_bits = ^line_address[OFS_W-1:0];
   assign w_wline_next       = ((r_state == S_IDLE) && line_write) ? line_wdata : r_wline;

   // Next-state and beat-counter decode; write has priority over read at acceptance.
   always_comb begin
      w_next_state = r_state;
      w_next_beat  = r_beat_cnt;
      case (r_state)
         S_IDLE: begin
            w_next_beat = {CNT_W{1'b0}};
            if (line_write) begin
               w_next_state = S_WR_BURST;
            end else if (line_read) begin
               w_next_state = S_RD_BURST;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_RD_BURST, S_WR_BURST: begin
            if (mem_resp) begin
               if (r_beat_cnt == LAST_BEAT) begin
                  w_next_state = S_DONE;
                  w_next_beat  = {CNT_W{1'b0}};
               end else begin
                  w_next_beat  = r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end else begin
               w_next_state = r_state;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
            w_next_beat  = {CNT_W{1'b0}};
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_beat  = {CNT_W{1'b0}};
         end
      endcase
   end

   // Read-line assembly: the incoming beat is merged into the partial buffer.
   always_comb begin
      w_rline = r_rbuf;
      if ((r_state == S_RD_BURST) && mem_resp) begin
         w_rline[int'(r_beat_cnt)*BURST_W +: BURST_W] = mem_rdata;
      end else begin
         w_rline = r_rbuf;
      end
   end

   // State, counters and registered bus outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_beat_cnt   <= {CNT_W{1'b0}};
         r_addr       <= {ADDR_W{1'b0}};
         r_wline      <= {LINE_W{1'b0}};
         r_rbuf       <= {LINE_W{1'b0}};
         r_line_rdata <= {LINE_W{1'b0}};
         r_line_resp  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_wdata  <= {BURST_W{1'b0}};
      end else begin
         r_state     <= w_next_state;
         r_beat_cnt  <= w_next_beat;
         r_wline     <= w_wline_next;
         r_rbuf      <= w_rline;
         r_line_resp <= (w_next_state == S_DONE);
         r_mem_read  <= (w_next_state == S_RD_BURST);
         r_mem_write <= (w_next_state == S_WR_BURST);
         r_mem_wdata <= (w_next_state == S_WR_BURST) ? f_beat(w_wline_next, w_next_beat)
                                                     : {BURST_W{1'b0}};
         if (w_accept) begin
            r_addr <= w_aligned_addr;
         end
         // The visible line only changes once the whole burst has arrived.
         if ((r_state == S_RD_BURST) && (w_next_state == S_DONE)) begin
            r_line_rdata <= w_rline;
         end
      end
   end

   assign line_rdata  = r_line_rdata;
   assign line_resp   = r_line_resp;
   assign mem_read    = r_mem_read;
   assign mem_write   = r_mem_write;
   assign mem_address = r_addr;
   assign mem_wdata   = r_mem_wdata;

`ifdef CACHELINE_ADAPTER_PERF_EN
   logic [31:0] r_perf_rd_cnt;
   logic [31:0] r_perf_wr_cnt;
   logic [31:0] r_perf_busy_cnt;

   // Saturating completion and busy-cycle counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_rd_cnt   <= 32'd0;
         r_perf_wr_cnt   <= 32'd0;
         r_perf_busy_cnt <= 32'd0;
      end else begin
         if ((r_state == S_RD_BURST) && (w_next_state == S_DONE) && (r_perf_rd_cnt != 32'hFFFF_FFFF)) begin
            r_perf_rd_cnt <= r_perf_rd_cnt + 32'd1;
         end
         if ((r_state == S_WR_BURST) && (w_next_state == S_DONE) && (r_perf_wr_cnt != 32'hFFFF_FFFF)) begin
            r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
         end
         if (((r_state == S_RD_BURST) || (r_state == S_WR_BURST)) && (r_perf_busy_cnt != 32'hFFFF_FFFF)) begin
            r_perf_busy_cnt <= r_perf_busy_cnt + 32'd1;
         end
      end
   end

   assign perf_rd_cnt   = r_perf_rd_cnt;
   assign perf_wr_cnt   = r_perf_wr_cnt;
   assign perf_busy_cnt = r_perf_busy_cnt;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, gapped reads, writes, read/write collision, mid-burst reset.
module tb_cacheline_adapter;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           line_read = 1'b0;
   logic           line_write = 1'b0;
   logic [31:0]    line_address = 32'd0;
   logic [255:0]   line_wdata = 256'd0;
   logic [255:0]   line_rdata;
   logic           line_resp;
   logic           mem_read;
   logic           mem_write;
   logic [31:0]    mem_address;
   logic [63:0]    mem_wdata;
   logic [63:0]    mem_rdata = 64'd0;
   logic           mem_resp = 1'b0;
`ifdef CACHELINE_ADAPTER_PERF_EN
   logic [31:0]    perf_rd_cnt;
   logic [31:0]    perf_wr_cnt;
   logic [31:0]    perf_busy_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int resp_cnt = 0;

   logic [255:0] line_a;
   logic [255:0] line_b;
   logic [255:0] line_w;

   cacheline_adapter dut (
      .clk          (clk),
      .rst          (rst),
`ifdef CACHELINE_ADAPTER_PERF_EN
      .perf_rd_cnt  (perf_rd_cnt),
      .perf_wr_cnt  (perf_wr_cnt),
      .perf_busy_cnt(perf_busy_cnt),
`endif
      .line_read    (line_read),
      .line_write   (line_write),
      .line_address (line_address),
      .line_wdata   (line_wdata),
      .line_rdata   (line_rdata),
      .line_resp    (line_resp),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp)
   );

   always #5 clk = ~clk;

   // Count completion pulses as seen at each rising edge.
   always @(posedge clk) begin
      if (line_resp === 1'b1) resp_cnt <= resp_cnt + 1;
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (line_rdata !== 256'd0) begin n_err++; $display("FAIL reset_line_rdata got=%h exp=0", line_rdata); end
      n_vec++; if (line_resp !== 1'b0) begin n_err++; $display("FAIL reset_line_resp got=%b exp=0", line_resp); end
      n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
      n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
      n_vec++; if (mem_address !== 32'd0) begin n_err++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
      n_vec++; if (mem_wdata !== 64'd0) begin n_err++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Full read transaction; memory supplies beats from exp_line, `gap` idle cycles before each.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] exp_line, input int gap);
      logic [63:0] beat;
      int          start_resp;
      start_resp   = resp_cnt;
      line_read    = 1'b1;
      line_address = addr;
      @(negedge clk);
      line_address = 32'hFFFF_FFFF;
      n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rd_mem_read_start got=%b exp=1", mem_read); end
      n_vec++; if (mem_address !== exp_addr) begin n_err++; $display("FAIL rd_mem_address got=%h exp=%h", mem_address, exp_addr); end
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            n_vec++; if (mem_read !== 1'b1 || line_resp !== 1'b0) begin n_err++; $display("FAIL rd_gap_hold got=%b/%b exp=1/0", mem_read, line_resp); end
            n_vec++; if (mem_address !== exp_addr) begin n_err++; $display("FAIL rd_gap_addr got=%h exp=%h", mem_address, exp_addr); end
         end
         beat      = exp_line[i*64 +: 64];
         mem_rdata = beat;
         mem_resp  = 1'b1;
         @(negedge clk);
         mem_resp  = 1'b0;
         mem_rdata = 64'd0;
      end
      n_vec++; if (line_resp !== 1'b1) begin n_err++; $display("FAIL rd_line_resp got=%b exp=1", line_resp); end
      n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rd_mem_read_drop got=%b exp=0", mem_read); end
      n_vec++; if (line_rdata !== exp_line) begin n_err++; $display("FAIL rd_line_rdata got=%h exp=%h", line_rdata, exp_line); end
      line_read = 1'b0;
      @(negedge clk);
      n_vec++; if (line_resp !== 1'b0) begin n_err++; $display("FAIL rd_resp_one_cycle got=%b exp=0", line_resp); end
      n_vec++; if (resp_cnt - start_resp !== 1) begin n_err++; $display("FAIL rd_resp_count got=%0d exp=1", resp_cnt - start_resp); end
   endtask

   // Full write transaction; also_read raises line_read alongside to check write priority.
   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [255:0] exp_rdata, input int gap, input logic also_read);
      logic [63:0] beat;
      int          start_resp;
      start_resp   = resp_cnt;
      line_write   = 1'b1;
      line_read    = also_read;
      line_address = addr;
      line_wdata   = line;
      @(negedge clk);
      line_wdata   = ~line;
      n_vec++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL wr_mem_write_start got=%b exp=1", mem_write); end
      n_vec++; if (mem_address !== addr) begin n_err++; $display("FAIL wr_mem_address got=%h exp=%h", mem_address, addr); end
      for (int i = 0; i < 4; i++) begin
         beat = line[i*64 +: 64];
         n_vec++; if (mem_wdata !== beat || mem_read !== 1'b0) begin n_err++; $display("FAIL wr_beat%0d got=%h rd=%b exp=%h rd=0", i, mem_wdata, mem_read, beat); end
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            n_vec++; if (mem_wdata !== beat || mem_write !== 1'b1) begin n_err++; $display("FAIL wr_gap_hold%0d got=%h/%b exp=%h/1", i, mem_wdata, mem_write, beat); end
         end
         mem_resp = 1'b1;
         @(negedge clk);
         mem_resp = 1'b0;
      end
      n_vec++; if (line_resp !== 1'b1) begin n_err++; $display("FAIL wr_line_resp got=%b exp=1", line_resp); end
      n_vec++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_err++; $display("FAIL wr_mem_drop got=%b/%b exp=0/0", mem_write, mem_read); end
      n_vec++; if (line_rdata !== exp_rdata) begin n_err++; $display("FAIL wr_rdata_kept got=%h exp=%h", line_rdata, exp_rdata); end
      line_write = 1'b0;
      line_read  = 1'b0;
      @(negedge clk);
      n_vec++; if (line_resp !== 1'b0 || mem_read !== 1'b0) begin n_err++; $display("FAIL wr_after got=%b/%b exp=0/0", line_resp, mem_read); end
      n_vec++; if (resp_cnt - start_resp !== 1) begin n_err++; $display("FAIL wr_resp_count got=%0d exp=1", resp_cnt - start_resp); end
   endtask

   task automatic test_read_basic();
      do_read(32'h0000_1234, 32'h0000_1220, line_a, 0);
   endtask

   task automatic test_read_gaps();
      do_read(32'h0000_5A7F, 32'h0000_5A60, line_b, 2);
   endtask

   task automatic test_write();
      do_write(32'h8000_0040, line_w, line_b, 1, 1'b0);
   endtask

   task automatic test_read_write_collision();
      do_write(32'h0000_2000, line_a, line_b, 0, 1'b1);
      do_read(32'h0000_3010, 32'h0000_3000, line_a, 0);
   endtask

   task automatic test_reset_mid_burst();
      int start_resp;
      start_resp   = resp_cnt;
      line_read    = 1'b1;
      line_address = 32'h0000_4444;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         mem_rdata = line_b[i*64 +: 64];
         mem_resp  = 1'b1;
         @(negedge clk);
      end
      mem_resp  = 1'b0;
      mem_rdata = 64'd0;
      #2;
      rst = 1'b0;
      #1;
      n_vec++; if (mem_read !== 1'b0 || line_resp !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl got=%b/%b exp=0/0", mem_read, line_resp); end
      n_vec++; if (mem_address !== 32'd0 || line_rdata !== 256'd0) begin n_err++; $display("FAIL rstmid_data got=%h/%h exp=0/0", mem_address, line_rdata); end
      line_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++; if (resp_cnt !== start_resp || mem_read !== 1'b0) begin n_err++; $display("FAIL rstmid_no_resp got=%0d/%b exp=%0d/0", resp_cnt, mem_read, start_resp); end
      do_read(32'h0000_4444, 32'h0000_4440, line_a, 0);
   endtask

`ifdef CACHELINE_ADAPTER_PERF_EN
   task automatic test_perf();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_read(32'h0000_0100, 32'h0000_0100, line_a, 0);
      do_read(32'h0000_0200, 32'h0000_0200, line_b, 0);
      do_read(32'h0000_0300, 32'h0000_0300, line_a, 0);
      do_write(32'h0000_0400, line_w, line_a, 0, 1'b0);
      do_write(32'h0000_0500, line_w, line_a, 0, 1'b0);
      n_vec++; if (perf_rd_cnt !== 32'd3) begin n_err++; $display("FAIL perf_rd got=%0d exp=3", perf_rd_cnt); end
      n_vec++; if (perf_wr_cnt !== 32'd2) begin n_err++; $display("FAIL perf_wr got=%0d exp=2", perf_wr_cnt); end
      n_vec++; if (perf_busy_cnt !== 32'd20) begin n_err++; $display("FAIL perf_busy got=%0d exp=20", perf_busy_cnt); end
      dut.r_perf_rd_cnt = 32'hFFFF_FFFF;
      do_read(32'h0000_0600, 32'h0000_0600, line_b, 0);
      n_vec++; if (perf_rd_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL perf_sat got=%h exp=ffffffff", perf_rd_cnt); end
   endtask
`endif

   initial begin
      line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      line_b = {64'hA5A5_0000_FFFF_0004, 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001};
      line_w = {64'hDEAD_0004_0000_BEEF, 64'hDEAD_0003_0000_BEEF,
                64'hDEAD_0002_0000_BEEF, 64'hDEAD_0001_0000_BEEF};
      test_reset();
      test_read_basic();
      test_read_gaps();
      test_write();
      test_read_write_collision();
      test_reset_mid_burst();
`ifdef CACHELINE_ADAPTER_PERF_EN
      test_perf();
`endif
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
